// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S / left-justified receive blocks.
//   cap_state_e : capture FSM states
//   DELAY_I2S   : data delay of 1 SCK after the WS edge (first bit is a dummy)
//   DELAY_LJ    : left-justified, MSB coincides with the WS edge
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LEFT,
        RIGHT
    } cap_state_e;

    localparam int DELAY_I2S = 1;
    localparam int DELAY_LJ  = 0;

endpackage

// File: rtl/sync_frame_fifo.sv
// Small synchronous FIFO with a registered head output.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear         : flush contents (wins over a same-cycle push)
//   push, wdata   : write request and data; accepted when not full or on a
//                   simultaneous pop
//   pop           : consume the head; ignored when empty
//   head          : registered copy of the oldest entry
//   full, empty   : occupancy flags
//   level         : number of stored entries, 0..DEPTH
module sync_frame_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, rd_q, rd_n;
    logic [LW-1:0]    cnt_q, cnt_n;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_do, pop_do;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == LW'(DEPTH));
    assign pop_do  = pop & ~empty;
    assign push_do = push & (~full | pop_do);

    // The head register is loaded with whatever entry will be oldest after
    // this cycle; when that entry is the one being written now, take it
    // straight from wdata since mem is not updated yet.
    always_comb begin
        rd_n   = rd_q + AW'(pop_do);
        cnt_n  = cnt_q + LW'(push_do) - LW'(pop_do);
        head_d = head_q;
        if (cnt_n != '0) begin
            if (push_do && (wr_q == rd_n)) head_d = wdata;
            else                           head_d = mem[rd_n];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else if (clear) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_q + AW'(push_do);
            rd_q   <= rd_n;
            cnt_q  <= cnt_n;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_do && !clear) mem[wr_q] <= wdata;
    end

    assign head  = head_q;
    assign level = cnt_q;

endmodule

// File: rtl/i2s_capture_multi.sv
// Multi-lane I2S / left-justified receiver. All lanes share one SCK/WS pair;
// each complete L+R frame of every lane is packed into one word and queued.
//   clk_i, rst_ni : system clock, asynchronous active-low reset
//   enable_i      : capture enable; low parks the FSM in IDLE (FIFO kept)
//   clear_i       : flush FIFO and clear overflow_o
//   sck_i, ws_i   : bit clock and word select (0 = left), synchronous to clk_i
//   sd_i          : one serial data bit per lane
//   frame_o       : FIFO head; lane l left at [2l*DATA_W], right at [(2l+1)*DATA_W]
//   valid_o/ready_i : head handshake
//   level_o       : FIFO occupancy
//   overflow_o    : sticky, a completed frame was dropped on a full FIFO
//   frame_err_o   : one-cycle pulse when a slot ends short of DATA_W bits
module i2s_capture_multi
    import i2s_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int SLOT_W     = 32,
    parameter int N_LANES    = 1,
    parameter int DELAY      = DELAY_I2S,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            enable_i,
    input  logic                            clear_i,
    input  logic                            sck_i,
    input  logic                            ws_i,
    input  logic [N_LANES-1:0]              sd_i,
    output logic [2*N_LANES*DATA_W-1:0]     frame_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [$clog2(FIFO_DEPTH):0]     level_o,
    output logic                            overflow_o,
    output logic                            frame_err_o
);

    localparam int FW   = 2 * N_LANES * DATA_W;
    localparam int CW   = $clog2(SLOT_W + 1);
    localparam int LAST = DELAY + DATA_W;   // bits needed for a complete slot

    typedef logic [FW-1:0] frame_t;

    cap_state_e state_q, state_d;
    logic       sck_q, ws_smp, bad_q, bad_d, err_d, push;
    logic       sck_rise, ws_chg, ws_fall, ws_rise, in_data, cap_l, cap_r;
    logic [CW-1:0] cnt_q, idx;
    int         idx_i;
    logic       full, empty, pop;
    frame_t     push_data, head;

    logic [N_LANES-1:0][DATA_W-1:0] left_q, right_q, right_nx;

    assign sck_rise = sck_i & ~sck_q;
    assign ws_chg   = sck_rise & (ws_i != ws_smp);
    assign ws_fall  = ws_chg & ~ws_i;
    assign ws_rise  = ws_chg & ws_i;

    // Bit index of the sample taken at this rise; a WS edge restarts the slot.
    assign idx      = ws_chg ? '0 : cnt_q;
    assign idx_i    = int'(idx);
    assign in_data  = sck_rise && (idx_i >= DELAY) && (idx_i < LAST);

    // Steering uses the next state so the bit sampled on a WS edge lands in
    // the slot that edge starts (matters for DELAY = 0).
    assign cap_l    = in_data && (state_d == LEFT);
    assign cap_r    = in_data && (state_d == RIGHT);

    always_comb begin
        state_d = state_q;
        bad_d   = bad_q;
        err_d   = 1'b0;
        push    = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SYNC;
                    bad_d   = 1'b0;
                end
                SYNC: begin
                    if (ws_fall) begin
                        state_d = LEFT;
                        bad_d   = 1'b0;
                    end
                end
                LEFT: begin
                    if (ws_rise) begin
                        state_d = RIGHT;
                        if (int'(cnt_q) < LAST) begin
                            err_d = 1'b1;
                            bad_d = 1'b1;
                        end
                    end
                end
                RIGHT: begin
                    if (ws_fall) begin
                        state_d = LEFT;
                        bad_d   = 1'b0;
                        if (int'(cnt_q) < LAST) err_d = 1'b1;
                    end else if (sck_rise && (idx_i == LAST - 1) && !bad_q) begin
                        push = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            bad_q       <= 1'b0;
            sck_q       <= 1'b0;
            ws_smp      <= 1'b0;
            cnt_q       <= '0;
            frame_err_o <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
        end else begin
            state_q     <= state_d;
            bad_q       <= bad_d;
            sck_q       <= sck_i;
            frame_err_o <= err_d;
            if (sck_rise) begin
                ws_smp <= ws_i;
                cnt_q  <= (idx_i < SLOT_W) ? idx + CW'(1) : idx;
            end
            for (int l = 0; l < N_LANES; l++) begin
                if (cap_l) left_q[l]  <= {left_q[l][DATA_W-2:0], sd_i[l]};
                if (cap_r) right_q[l] <= right_nx[l];
            end
        end
    end

    // The push happens on the rise that samples the last right bit, so the
    // pushed word takes the right channel from the shifter's next value.
    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        assign right_nx[l] = {right_q[l][DATA_W-2:0], sd_i[l]};
        assign push_data[2*l*DATA_W +: DATA_W]     = left_q[l];
        assign push_data[(2*l+1)*DATA_W +: DATA_W] = right_nx[l];
    end

    assign pop = ~empty & ready_i;

    sync_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (clear_i),
        .push   (push),
        .wdata  (push_data),
        .pop    (pop),
        .head   (head),
        .full   (full),
        .empty  (empty),
        .level  (level_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                      overflow_o <= 1'b0;
        else if (clear_i)                 overflow_o <= 1'b0;
        else if (push && full && !pop)    overflow_o <= 1'b1;
    end

    assign frame_o = head;
    assign valid_o = ~empty;

endmodule

// File: tb/tb_i2s_capture_multi.sv
module tb_i2s_capture_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, clr;
    logic sck_a, ws_a, sd_a0;
    logic [1:0] sd_a2;
    logic sck_b, ws_b, sd_b;
    logic rdy0, rdy1, rdy2;

    logic [47:0] fr0;  logic [31:0] fr1;  logic [95:0] fr2;
    logic        valid0, valid1, valid2;
    logic [2:0]  level0, level1, level2;
    logic        ovf0, ovf1, ovf2, err0, err1, err2;

    int tests = 0, fails = 0;
    int nerr0 = 0, nerr1 = 0, nerr2 = 0;
    logic [47:0] q0[$];
    logic [31:0] q1[$];
    logic [95:0] q2[$];

    // u0: defaults (I2S, 24/32, one lane)
    i2s_capture_multi u0 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr),
        .sck_i(sck_a), .ws_i(ws_a), .sd_i(sd_a0),
        .frame_o(fr0), .valid_o(valid0), .ready_i(rdy0), .level_o(level0),
        .overflow_o(ovf0), .frame_err_o(err0));

    // u1: left-justified 16/16
    i2s_capture_multi #(.DATA_W(16), .SLOT_W(16), .DELAY(0)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr),
        .sck_i(sck_b), .ws_i(ws_b), .sd_i(sd_b),
        .frame_o(fr1), .valid_o(valid1), .ready_i(rdy1), .level_o(level1),
        .overflow_o(ovf1), .frame_err_o(err1));

    // u2: two lanes on the same SCK/WS as u0
    i2s_capture_multi #(.N_LANES(2)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr),
        .sck_i(sck_a), .ws_i(ws_a), .sd_i(sd_a2),
        .frame_o(fr2), .valid_o(valid2), .ready_i(rdy2), .level_o(level2),
        .overflow_o(ovf2), .frame_err_o(err2));

    // Scoreboard side: every accepted head must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n && valid0 && rdy0) begin
            tests++;
            assert (q0.size() != 0) else begin fails++; $error("FAIL u0_unexpected got %h want none", fr0); end
            if (q0.size() != 0) begin
                logic [47:0] e0;
                e0 = q0.pop_front();
                tests++;
                assert (fr0 === e0) else begin fails++; $error("FAIL u0_frame got %h want %h", fr0, e0); end
            end
        end
        if (rst_n && valid1 && rdy1) begin
            tests++;
            assert (q1.size() != 0) else begin fails++; $error("FAIL u1_unexpected got %h want none", fr1); end
            if (q1.size() != 0) begin
                logic [31:0] e1;
                e1 = q1.pop_front();
                tests++;
                assert (fr1 === e1) else begin fails++; $error("FAIL u1_frame got %h want %h", fr1, e1); end
            end
        end
        if (rst_n && valid2 && rdy2) begin
            tests++;
            assert (q2.size() != 0) else begin fails++; $error("FAIL u2_unexpected got %h want none", fr2); end
            if (q2.size() != 0) begin
                logic [95:0] e2;
                e2 = q2.pop_front();
                tests++;
                assert (fr2 === e2) else begin fails++; $error("FAIL u2_frame got %h want %h", fr2, e2); end
            end
        end
        if (err0) nerr0++;
        if (err1) nerr1++;
        if (err2) nerr2++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin fails++; $error("FAIL %s got %0h want %0h", tag, obs, exp); end
    endtask

    // I2S 24-bit slot: index 0 is the dummy bit, 1..24 MSB..LSB, rest zero.
    function automatic logic dbit(input logic [23:0] v, input int i);
        if (i >= 1 && i <= 24) return v[24-i];
        return 1'b0;
    endfunction

    function automatic logic dbit16(input logic [15:0] v, input int i);
        if (i < 16) return v[15-i];
        return 1'b0;
    endfunction

    // One SCK period on bus A: 2 clk low then 2 clk high. With lat set, the
    // rise is the last right data bit: u0 valid must rise exactly one clk later.
    task automatic bit_a(input logic w, input logic s0, input logic [1:0] s2, input bit lat);
        @(negedge clk); sck_a = 1'b0; ws_a = w; sd_a0 = s0; sd_a2 = s2;
        @(negedge clk);
        @(negedge clk); sck_a = 1'b1;
        if (lat) begin
            chk("lat_valid_before", valid0, 1'b0);
            @(posedge clk); #1;
            chk("lat_valid_after", valid0, 1'b1);
            chk("lat_level", level0, 3'd1);
        end
        @(negedge clk);
    endtask

    task automatic bit_b(input logic w, input logic s);
        @(negedge clk); sck_b = 1'b0; ws_b = w; sd_b = s;
        @(negedge clk);
        @(negedge clk); sck_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_a(input logic [23:0] l0, input logic [23:0] r0,
                          input logic [23:0] l1, input logic [23:0] r1,
                          input int lb, input int rb, input bit exp0, input bit lat);
        if (lb >= 25 && rb >= 25) begin
            if (exp0) q0.push_back({r0, l0});
            q2.push_back({r1, l1, r0, l0});
        end
        for (int i = 0; i < lb; i++) bit_a(1'b0, dbit(l0, i), {dbit(l1, i), dbit(l0, i)}, 1'b0);
        for (int i = 0; i < rb; i++) bit_a(1'b1, dbit(r0, i), {dbit(r1, i), dbit(r0, i)}, lat && (i == 24));
    endtask

    task automatic send_b(input logic [15:0] l, input logic [15:0] r);
        q1.push_back({r, l});
        for (int i = 0; i < 16; i++) bit_b(1'b0, dbit16(l, i));
        for (int i = 0; i < 16; i++) bit_b(1'b1, dbit16(r, i));
    endtask

    task automatic set_rdy0(input logic v);
        @(posedge clk); #1 rdy0 = v;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; clr = 1'b0;
        sck_a = 1'b0; ws_a = 1'b0; sd_a0 = 1'b0; sd_a2 = 2'b00;
        sck_b = 1'b0; ws_b = 1'b0; sd_b = 1'b0;
        rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_valid0", valid0, 1'b0);
        chk("rst_level0", level0, 3'd0);
        chk("rst_ovf0", ovf0, 1'b0);
        chk("rst_frame0", fr0, 48'h0);
        chk("rst_err0", err0, 1'b0);
        chk("rst_valid1", valid1, 1'b0);
        chk("rst_valid2", valid2, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Right-channel preamble so the first frame starts on a WS 1->0 edge.
        for (int i = 0; i < 4; i++) bit_a(1'b1, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) bit_b(1'b1, 1'b0);

        // Full-scale values plus latency check; then the lane-packing pattern.
        send_a(24'h800001, 24'h7FFFFE, 24'h123456, 24'h654321, 32, 32, 1'b1, 1'b1);
        send_a(24'h000001, 24'h000002, 24'h000003, 24'h000004, 32, 32, 1'b1, 1'b0);

        // Left-justified, no dummy bit.
        send_b(16'h1234, 16'hABCD);
        send_b(16'h8000, 16'h7FFF);

        // Short left slot: error pulse, frame dropped, next frame normal.
        send_a(24'hAAAAAA, 24'h555555, 24'h111111, 24'h222222, 10, 32, 1'b1, 1'b0);
        send_a(24'h000100, 24'hFFFFFF, 24'hC0FFEE, 24'hBEEF01, 32, 32, 1'b1, 1'b0);
        chk("short_left_err0", nerr0, 1);
        chk("short_left_err2", nerr2, 1);

        // Short right slot: error reported at the next WS 1->0 edge.
        send_a(24'h0F0F0F, 24'hF0F0F0, 24'h333333, 24'h444444, 32, 10, 1'b1, 1'b0);
        send_a(24'h13579B, 24'h2468AC, 24'h0A0A0A, 24'h050505, 32, 32, 1'b1, 1'b0);
        chk("short_right_err0", nerr0, 2);
        chk("short_right_err2", nerr2, 2);

        // Reset mid right slot: outputs clear at once, partial frame discarded.
        send_a(24'h777777, 24'h888888, 24'h999999, 24'hAAAAAA, 32, 12, 1'b1, 1'b0);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("arst_frame0", fr0, 48'h0);
        chk("arst_valid0", valid0, 1'b0);
        chk("arst_level0", level0, 3'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) bit_a(1'b1, 1'b0, 2'b00, 1'b0);
        send_a(24'h00ABCD, 24'hFEDCBA, 24'h010203, 24'h040506, 32, 32, 1'b1, 1'b0);
        chk("arst_no_err0", nerr0, 2);

        // enable_i low mid right slot: discard, resync, no error.
        send_a(24'h101010, 24'h202020, 24'h303030, 24'h404040, 32, 12, 1'b1, 1'b0);
        @(negedge clk); en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 20; i++) bit_a(1'b1, 1'b1, 2'b11, 1'b0);
        send_a(24'h5A5A5A, 24'hA5A5A5, 24'h0000FF, 24'hFF0000, 32, 32, 1'b1, 1'b0);
        chk("en_no_err0", nerr0, 2);
        chk("en_no_err2", nerr2, 2);

        // Overflow: five frames into a four-deep FIFO with ready low.
        set_rdy0(1'b0);
        for (int f = 0; f < 5; f++)
            send_a(24'h100000 + 24'(f), 24'h200000 + 24'(f), 24'h300000, 24'h400000, 32, 32, f < 4, 1'b0);
        chk("ovf_level", level0, 3'd4);
        chk("ovf_flag", ovf0, 1'b1);
        chk("ovf_valid", valid0, 1'b1);
        chk("ovf_head", fr0, 48'h200000_100000);
        set_rdy0(1'b1);
        for (int k = 0; k < 60 && level0 != 3'd0; k++) @(negedge clk);
        chk("ovf_drained", level0, 3'd0);
        chk("ovf_q0_empty", q0.size(), 0);
        chk("ovf_sticky", ovf0, 1'b1);
        pulse_clr();
        chk("clr_ovf", ovf0, 1'b0);

        // clear_i flushes a stored frame.
        set_rdy0(1'b0);
        send_a(24'h0C0C0C, 24'h0D0D0D, 24'h0E0E0E, 24'h0F0F0F, 32, 32, 1'b0, 1'b0);
        chk("flush_valid_pre", valid0, 1'b1);
        chk("flush_level_pre", level0, 3'd1);
        pulse_clr();
        chk("flush_valid", valid0, 1'b0);
        chk("flush_level", level0, 3'd0);
        set_rdy0(1'b1);

        for (int k = 0; k < 200 && (q0.size() + q1.size() + q2.size()) != 0; k++) @(negedge clk);
        chk("end_q0", q0.size(), 0);
        chk("end_q1", q1.size(), 0);
        chk("end_q2", q2.size(), 0);
        chk("end_err1", nerr1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2s_capture_multi.md
Name: i2s_capture_multi

Overview:
Parametrised multi-lane I²S/left-justified receiver. Captures N_LANES stereo serial data lines that share one SCK/WS pair. Each complete L+R frame is packed into one word and buffered in a small FIFO with valid/ready output. Sits between i2s_clock_gen and the downstream audio DSP/packetiser, and adds framing-error and overflow reporting.

Parameters:
DATA_W, 24, captured sample width (bits, signed two's complement, MSB-first)
SLOT_W, 32, SCK periods per channel slot; bits past DELAY+DATA_W ignored
N_LANES, 1, number of parallel sd lines (each lane carries L+R)
DELAY, 1, data delay after WS change: 1 = I²S (first bit is a dummy), 0 = left-justified
FIFO_DEPTH, 4, frames buffered; power of 2, >= 2

Ports:
clk_i  in  1  system clock; sck_i/ws_i/sd_i are synchronous to it
rst_ni  in  1  reset, asynchronous, active-low
enable_i  in  1  capture enable; low forces FSM to IDLE, FIFO retained
clear_i  in  1  single-cycle clear of sticky flags and FIFO flush
sck_i  in  1  serial bit clock from i2s_clock_gen
ws_i  in  1  word select: 0 = left, 1 = right
sd_i  in  N_LANES  serial data, one bit per lane
frame_o  out  2*N_LANES*DATA_W  lane l: left at [2l*DATA_W +: DATA_W], right at [(2l+1)*DATA_W +: DATA_W]
valid_o  out  1  frame_o holds the FIFO head
ready_i  in  1  consumer accepts the head on valid_o && ready_i
level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow_o  out  1  sticky: a frame was dropped because the FIFO was full
frame_err_o  out  1  one-cycle pulse: slot ended before DATA_W bits were captured

Behaviour:
- Reset values: frame_o=0, valid_o=0, level_o=0, overflow_o=0, frame_err_o=0; FSM=IDLE; shifters, counters and ws_smp cleared.
- sck_rise = sck_i high && previous-cycle sck_i low. On each sck_rise: sd_i and ws_i are sampled in that same clk cycle, and ws_smp <= ws_i. A WS change is ws_i != ws_smp at an sck_rise; it starts a new slot with bit counter cnt=0.
- Bit handling: the bit sampled at counter value cnt is shifted into the channel shifter only when DELAY <= cnt < DELAY+DATA_W. cnt saturates at SLOT_W; extra bits are ignored with no error.
- FSM states: IDLE, SYNC, LEFT, RIGHT.
  - IDLE -> SYNC when enable_i=1.
  - SYNC -> LEFT on a WS 1->0 change. Any partial right slot present at startup is discarded.
  - LEFT -> RIGHT on a WS 0->1 change. Left is valid iff DELAY+DATA_W bits were seen; otherwise pulse frame_err_o and mark the frame bad.
  - RIGHT -> LEFT on a WS 1->0 change.
  - Any state -> IDLE when enable_i=0; the partial frame is discarded and no error is raised.
- Frame push: in RIGHT, at the sck_rise on which the last right data bit is captured, the frame is pushed if not marked bad. The bad mark clears on entry to LEFT.
- A short right slot (WS 1->0 change before completion) pulses frame_err_o; nothing is pushed.
- Latency: valid_o rises on the clk cycle after the push when the FIFO was empty. frame_o is registered (FIFO head).
- FIFO: a push is accepted if not full, or if a pop happens in the same cycle. A push when full with no pop drops the new frame and sets overflow_o; stored frames are unchanged.
- Simultaneous push and pop when empty: the pop does nothing (valid_o=0), the push is stored.
- Read/write pointers wrap modulo FIFO_DEPTH. level_o ranges 0..FIFO_DEPTH.
- clear_i: flushes the FIFO (valid_o=0 next cycle) and clears overflow_o. If a push and clear_i coincide, clear_i wins.
- Asynchronous reset mid-frame: immediate return to reset values. After release, capture waits for SYNC.

Decomposition:
- i2s_pkg: cap_state_e enum (IDLE, SYNC, LEFT, RIGHT); DELAY_I2S=1 and DELAY_LJ=0 constants; frame_t is typedef'd per instance.
- Sub-module sync_frame_fifo (WIDTH, DEPTH): push/pop, full/empty/level, registered head output. It is reusable by other audio RX blocks.

Test Plan:
1. Defaults, 32-bit slots: send L=0x800001, R=0x7FFFFE -> frame_o=0x7FFFFE_800001, valid_o=1 one clk after the last right bit, level_o=1.
2. DELAY=0, DATA_W=16, SLOT_W=16: send L=0x1234, R=0xABCD with no dummy bit -> frame_o=0xABCD_1234.
3. N_LANES=2: lane0 L/R=0x000001/0x000002, lane1 L/R=0x000003/0x000004 -> frame_o=0x000004_000003_000002_000001.
4. ready_i=0, FIFO_DEPTH=4, send 5 frames -> level_o=4, overflow_o=1, frames 1-4 read out in order after ready_i=1, frame 5 absent; clear_i -> overflow_o=0.
5. WS toggles after 10 left bits -> frame_err_o pulse, no push for that frame; the next full frame is captured normally.
6. Reset released mid right slot; also enable_i toggled low mid-frame -> no push until a WS 1->0 change followed by a complete L+R; no frame_err_o.
